// File: rtl/johnson_digit_display_if.sv
// rtl/johnson_digit_display_if.sv - digit inputs and display outputs of johnson_digit_display
//   i_100/i_010/i_001 : Johnson-coded hundreds/tens/units digits
//   i_hold            : keep previous snapshot at next frame start
//   o_seg/o_dp        : {g,f,e,d,c,b,a} segments and decimal point, active-high
//   o_digit           : 2/1/0 = hundreds/tens/units shown, 3 = none
//   o_frame           : one-cycle pulse in the snapshot cycle
interface johnson_digit_display_if;
  logic [4:0] i_100;
  logic [4:0] i_010;
  logic [4:0] i_001;
  logic       i_hold;
  logic [6:0] o_seg;
  logic       o_dp;
  logic [1:0] o_digit;
  logic       o_frame;

  modport slave (
    input  i_100, i_010, i_001, i_hold,
    output o_seg, o_dp, o_digit, o_frame
  );

  modport master (
    output i_100, i_010, i_001, i_hold,
    input  o_seg, o_dp, o_digit, o_frame
  );
endinterface

// File: rtl/johnson_digit_display.sv
// rtl/johnson_digit_display.sv - frame sequencer showing a 3-digit Johnson-coded value on one 7-seg digit
//   i_clk : display clock
//   i_rst : synchronous active-high reset
//   bus   : slave side of johnson_digit_display_if (digit inputs, i_hold, display outputs)
module johnson_digit_display #(
  parameter int pHOLD     = 4,
  parameter int pGAP      = 1,
  parameter int pEND      = 4,
  parameter int pBLANK_LZ = 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  johnson_digit_display_if.slave   bus
);

  localparam int MAXV = (pHOLD > pGAP) ? ((pHOLD > pEND) ? pHOLD : pEND)
                                       : ((pGAP > pEND) ? pGAP : pEND);
  localparam int CW   = $clog2(MAXV + 1);

  // Counter holds remaining cycles minus one, so a state of length N loads N-1.
  localparam logic [CW-1:0] HOLD_RL = CW'(pHOLD - 1);
  localparam logic [CW-1:0] GAP_RL  = (pGAP > 0) ? CW'(pGAP - 1) : '0;
  localparam logic [CW-1:0] END_RL  = CW'(pEND - 1);

  typedef enum logic [1:0] {
    S_SNAP = 2'd0,
    S_DIG  = 2'd1,
    S_GAP  = 2'd2,
    S_END  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    snap_100_q, snap_100_d;
  logic [4:0]    snap_010_q, snap_010_d;
  logic [4:0]    snap_001_q, snap_001_d;

  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic [1:0]    digit_q, digit_d;
  logic          frame_q, frame_d;

  // Returns {valid, value}; only the ten legal Johnson codes are valid.
  function automatic logic [4:0] jdec(input logic [4:0] code);
    logic [4:0] r;
    case (code)
      5'b00000: r = {1'b1, 4'd0};
      5'b00001: r = {1'b1, 4'd1};
      5'b00011: r = {1'b1, 4'd2};
      5'b00111: r = {1'b1, 4'd3};
      5'b01111: r = {1'b1, 4'd4};
      5'b11111: r = {1'b1, 4'd5};
      5'b11110: r = {1'b1, 4'd6};
      5'b11100: r = {1'b1, 4'd7};
      5'b11000: r = {1'b1, 4'd8};
      5'b10000: r = {1'b1, 4'd9};
      default:  r = {1'b0, 4'd0};
    endcase
    return r;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  // Next-state, snapshot and counter.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = (cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;
    snap_100_d = snap_100_q;
    snap_010_d = snap_010_q;
    snap_001_d = snap_001_q;
    case (state_q)
      S_SNAP: begin
        state_d = S_DIG;
        idx_d   = 2'd2;
        cnt_d   = HOLD_RL;
        if (!bus.i_hold) begin
          snap_100_d = bus.i_100;
          snap_010_d = bus.i_010;
          snap_001_d = bus.i_001;
        end
      end
      S_DIG: begin
        if (cnt_q == '0) begin
          if (idx_q == 2'd0) begin
            state_d = S_END;
            cnt_d   = END_RL;
          end else if (pGAP > 0) begin
            state_d = S_GAP;
            cnt_d   = GAP_RL;
          end else begin
            idx_d   = idx_q - 2'd1;
            cnt_d   = HOLD_RL;
          end
        end
      end
      S_GAP: begin
        if (cnt_q == '0) begin
          state_d = S_DIG;
          idx_d   = idx_q - 2'd1;
          cnt_d   = HOLD_RL;
        end
      end
      S_END: begin
        if (cnt_q == '0) begin
          state_d = S_SNAP;
          cnt_d   = '0;
        end
      end
      default: state_d = S_SNAP;
    endcase
  end

  // Output decode works on next-state values so the registered outputs
  // line up with the state being held in the same cycle.
  logic [4:0] dec_h, dec_t, dec_sel;
  logic       blank;

  always_comb begin
    seg_d   = 7'h00;
    dp_d    = 1'b0;
    digit_d = 2'd3;
    frame_d = 1'b0;
    dec_h   = jdec(snap_100_d);
    dec_t   = jdec(snap_010_d);
    case (idx_d)
      2'd2:    dec_sel = dec_h;
      2'd1:    dec_sel = dec_t;
      default: dec_sel = jdec(snap_001_d);
    endcase
    // An invalid hundreds code is not "0", so it never blanks the tens.
    blank = (pBLANK_LZ != 0) &&
            (((idx_d == 2'd2) && (dec_h == 5'b10000)) ||
             ((idx_d == 2'd1) && (dec_h == 5'b10000) && (dec_t == 5'b10000)));
    case (state_d)
      S_SNAP: frame_d = 1'b1;
      S_DIG: begin
        digit_d = idx_d;
        if (!dec_sel[4])
          seg_d = 7'h79;
        else if (!blank)
          seg_d = seg7(dec_sel[3:0]);
      end
      S_END:   dp_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= S_SNAP;
      idx_q      <= 2'd2;
      cnt_q      <= '0;
      snap_100_q <= 5'b00000;
      snap_010_q <= 5'b00000;
      snap_001_q <= 5'b00000;
      seg_q      <= 7'h00;
      dp_q       <= 1'b0;
      digit_q    <= 2'd3;
      frame_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      snap_100_q <= snap_100_d;
      snap_010_q <= snap_010_d;
      snap_001_q <= snap_001_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      digit_q    <= digit_d;
      frame_q    <= frame_d;
    end
  end

  assign bus.o_seg   = seg_q;
  assign bus.o_dp    = dp_q;
  assign bus.o_digit = digit_q;
  assign bus.o_frame = frame_q;

endmodule
